flopenr_pipe: RTL and testbench
===============================

Name: flopenr_pipe

Overview:
- Parametrised successor to the single enable/reset flop: a DEPTH-stage elastic pipeline register, WIDTH bits per stage, with a valid/ready handshake.
- Each stage has its own valid bit. Stages advance independently, so bubbles collapse.
- A synchronous flush empties the pipe.
- Used between datapath stages that need stall/flush without a full FIFO (e.g. IFU/LSU staging).

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_VAL, '0, WIDTH-bit value loaded into every stage's data on reset and on flush.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; empties all stages.
- in_valid  input  1  upstream has data on in_data.
- in_ready  output  1  pipe accepts in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  data of stage DEPTH-1.
- occ  output  $clog2(DEPTH+1)  number of valid stages (only with PIPE_OCC_EN).

Behaviour:
- Reset (reset_n=0, asynchronous): all valid[i]=0 and data[i]=RESET_VAL.
  - Outputs: out_valid=0, out_data=RESET_VAL, in_ready=0 while reset_n=0, occ=0.
- Per-stage move signals, i = DEPTH-1 down to 0:
  - adv[DEPTH-1] = !valid[DEPTH-1] | out_ready.
  - adv[i] = !valid[i] | (valid[i+1]==0) | adv[i+1]. Equivalently, stage i can accept new data if it is empty, or if its content moves on.
  - in_ready = adv[0] & !flush & reset_n.
- Stage 0 update: if adv[0], then valid[0] <= in_valid & in_ready, and data[0] <= in_data when that load occurs.
- Stage i>0 update: if adv[i], then valid[i] <= valid[i-1], and data[i] <= data[i-1] when valid[i-1].
- Stage held (adv[i]=0): data and valid unchanged.
- Empty stages:
  - Data does not toggle. A stage only loads when valid data moves into it.
  - out_data of an empty stage is the last value held, or RESET_VAL after reset/flush. Consumers must qualify out_data with out_valid.
- Latency and throughput:
  - Empty pipe, no stall: datum accepted at edge N appears on out_data/out_valid after edge N+DEPTH-1, i.e. DEPTH cycles of latency.
  - Throughput is 1 item/cycle when out_ready=1.
- Full pipe (all valid) with out_ready=0: in_ready=0 and no state changes.
- Full pipe with out_ready=1: simultaneous push and pop, in_ready=1, occupancy unchanged.
- Bubble collapse: with out_ready=0 and a hole at stage k, stages below k still advance until the pipe is packed toward the output.
- Flush (synchronous, highest priority below reset):
  - At the next edge: all valid<=0 and all data<=RESET_VAL.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - out_valid is registered and not gated by flush. If out_valid&out_ready occur in the flush cycle, that transfer is complete.
- Reset asserted mid-operation: immediate clear regardless of handshakes. The first acceptance is possible in the first cycle after reset_n deasserts.
- Signal dependencies:
  - out_valid and out_data are pure register outputs.
  - in_ready depends combinationally on out_ready (ripple through adv). This is a combinational ready path of DEPTH levels.
- DEPTH=1 degenerates to a single valid/ready register with a flush.

Optional Feature:
- Macro PIPE_OCC_EN.
- When defined:
  - occ port exists. It is a registered count of valid stages.
  - Updated every edge: +1 on accept only, -1 on output transfer only, unchanged on both or neither.
  - Forced to 0 on reset and on flush. On flush with a simultaneous output transfer, occ still becomes 0.
  - Must always equal popcount(valid). A simulation assertion checks this.
- When undefined: occ port and counter are absent. Core behaviour is identical.

Test Plan:
- All tests use WIDTH=8, DEPTH=3, RESET_VAL=8'hA5.
- Reset check: reset_n=0 mid-stream with 2 items held -> out_valid=0 and out_data=8'hA5 immediately (before the next edge); occ=0; in_ready=1 in the first cycle after release.
- Streaming: push 8'h01,8'h02,8'h03,8'h04 on consecutive cycles, out_ready=1 -> out_data 01..04 on cycles 3..6 after the first accept, out_valid continuous, in_ready never drops.
- Backpressure: out_ready=0, push 5 items -> exactly 3 accepted, in_ready=0 after the 3rd, occ=3. Then out_ready=1 for 1 cycle -> 01 leaves, 04 is accepted the same cycle, occ stays 3.
- Bubble collapse: accept 8'h10, idle 1 cycle, accept 8'h11, out_ready=0 -> 10 reaches stage 2, 11 packs into stage 1 by the next edge. out_ready=1 -> 10 then 11 on back-to-back cycles.
- Flush with output transfer: pipe full (20,21,22), out_ready=1, flush=1, in_valid=1 -> 20 counts as transferred; in_ready=0 and the input is not accepted; next cycle out_valid=0, out_data=8'hA5, occ=0.
- Flush on empty pipe with in_valid=1 -> no accept; out_valid stays 0 for 3 cycles.

Source files
------------

// File: rtl/flopenr_pipe.sv
// flopenr_pipe: DEPTH-stage elastic valid/ready pipeline register with per-stage valids and sync flush.
// Define PIPE_OCC_EN to add the registered occupancy count port occ.
module flopenr_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [DEPTH-1:0]            w_adv;
  logic                        w_load;
  logic                        w_pop;
  // Ready ripples from the output back toward stage 0.
  always_comb begin
    w_adv = '0;
    w_adv[DEPTH-1] = !r_valid[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--)
      w_adv[i] = !r_valid[i] | !r_valid[i+1] | w_adv[i+1];
  end
  assign in_ready  = w_adv[0] & !flush & reset_n;
  assign w_load    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush) begin
      r_valid <= '0;
      r_data  <= {DEPTH{RESET_VAL}};
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= w_load;
        if (w_load) r_data[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_valid[i] <= r_valid[i-1];
          if (r_valid[i-1]) r_data[i] <= r_data[i-1];
        end
      end
    end
  end
`ifdef PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH+1);
  logic [OW-1:0] r_occ;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush) r_occ <= '0;
    else                   r_occ <= r_occ + OW'(w_load) - OW'(w_pop);
  end
  assign occ = r_occ;
  a_occ_popcount: assert property (@(posedge clk) disable iff (!reset_n) int'(r_occ) == $countones(r_valid));
`endif
endmodule

// File: tb/tb_flopenr_pipe.sv
// tb_flopenr_pipe: directed scoreboard bench for flopenr_pipe (WIDTH=8, DEPTH=3, RESET_VAL=A5).
module tb_flopenr_pipe;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
`ifdef PIPE_OCC_EN
  logic [1:0] occ;
`endif
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  flopenr_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_OCC_EN
    , .occ(occ)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_occ(input string nm, input logic [31:0] exp);
`ifdef PIPE_OCC_EN
    chk(nm, 32'(occ), exp);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  // Monitor: every output transfer is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin : mon
      logic [7:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got %0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_err++;
          $display("FAIL out_data: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) cyc();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 32'hA5);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk_occ("rst_occ", 0);
    reset_n = 1'b1;
    #1 chk("rel_in_ready", 32'(in_ready), 1);

    // Streaming: 01..04 back to back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i + 1);
      exp_q.push_back(8'(i + 1));
      chk("stream_in_ready", 32'(in_ready), 1);
      cyc();
    end
    idle();
    repeat (3) begin
      chk("stream_out_valid", 32'(out_valid), 1);
      cyc();
    end
    chk("stream_empty", 32'(out_valid), 0);

    // Backpressure: only three of the offered items fit
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i + 1);
      chk("bp_in_ready", 32'(in_ready), 1);
      cyc();
    end
    in_data = 8'h04;
    chk("bp_full_in_ready", 32'(in_ready), 0);
    chk_occ("bp_occ_full", 3);
    cyc();
    chk("bp_hold_in_ready", 32'(in_ready), 0);
    chk("bp_hold_out", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    exp_q.push_back(8'h01);
    #1 chk("bp_pushpop_in_ready", 32'(in_ready), 1);
    cyc();
    chk_occ("bp_occ_pushpop", 3);
    out_ready = 1'b0;
    in_data = 8'h05;
    #1 chk("bp_full_again", 32'(in_ready), 0);
    idle();
    out_ready = 1'b1;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h04);
    repeat (3) cyc();
    chk("bp_drained", 32'(out_valid), 0);

    // Bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h10;
    cyc();
    idle();
    cyc();
    in_valid = 1'b1;
    in_data = 8'h11;
    cyc();
    idle();
    chk("bub_out_data", 32'(out_data), 32'h10);
    chk_occ("bub_occ", 2);
    cyc();
    chk("bub_hold_valid", 32'(out_valid), 1);
    chk("bub_hold_data", 32'(out_data), 32'h10);
    out_ready = 1'b1;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    cyc();
    chk("bub_b2b_valid", 32'(out_valid), 1);
    chk("bub_b2b_data", 32'(out_data), 32'h11);
    cyc();
    chk("bub_drained", 32'(out_valid), 0);

    // Flush with a simultaneous output transfer
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h20 + i);
      cyc();
    end
    out_ready = 1'b1;
    flush = 1'b1;
    in_data = 8'h23;
    exp_q.push_back(8'h20);
    #1 chk("fl_in_ready", 32'(in_ready), 0);
    cyc();
    idle();
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_out_data", 32'(out_data), 32'hA5);
    chk_occ("fl_occ", 0);

    // Flush on an empty pipe
    in_valid = 1'b1;
    in_data = 8'h33;
    flush = 1'b1;
    #1 chk("fle_in_ready", 32'(in_ready), 0);
    cyc();
    idle();
    repeat (3) begin
      chk("fle_out_valid", 32'(out_valid), 0);
      cyc();
    end

    // Reset mid-stream with two items held
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h30 + i);
      cyc();
    end
    idle();
    cyc();
    chk("mr_pre_valid", 32'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_out_data", 32'(out_data), 32'hA5);
    chk("mr_in_ready", 32'(in_ready), 0);
    chk_occ("mr_occ", 0);
    cyc();
    reset_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h40;
    exp_q.push_back(8'h40);
    #1 chk("mr_first_ready", 32'(in_ready), 1);
    cyc();
    idle();
    repeat (2) cyc();
    chk("mr_40_valid", 32'(out_valid), 1);
    cyc();
    chk("mr_drained", 32'(out_valid), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
